// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - control-kind encodings, sequential-PC and counter helpers for the branch predictor
package bp_pkg;

  localparam logic [1:0] KIND_BR   = 2'd0;
  localparam logic [1:0] KIND_J    = 2'd1;
  localparam logic [1:0] KIND_CALL = 2'd2;
  localparam logic [1:0] KIND_RET  = 2'd3;

  // Bit 31 selects the kernel segment, so the increment must never carry into it
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  function automatic int CTR_INIT(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

  function automatic int CTR_ALLOC(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/bp_ras.sv
// rtl/bp_ras.sv - circular return-address stack; a full push overwrites the oldest, an empty pop is ignored
module bp_ras #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] push_data_i,
  output logic [31:0] top_o,
  output logic        empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W:0]   cnt_q, cnt_d;

  // ptr_q names the next free slot; the pointer wraps naturally
  assign top_ptr = ptr_q - 1'b1;
  assign top_o   = mem_q[top_ptr];
  assign empty_o = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && cnt_q != '0) begin
      ptr_d = top_ptr;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (push_i) mem_q[ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - BTB with saturating direction counters; zero-cycle lookup, EX-stage training
// Define BTP_RAS_EN to steer return predictions through a bp_ras return stack.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int CTR_W     = 2,
  parameter int TAG_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lk_pc,
  output logic [31:0] lk_next_pc,
  output logic        lk_taken,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic [1:0]  up_kind,
  input  logic        up_taken,
  input  logic [31:0] up_target,
  input  logic        up_pred_taken,
  input  logic [31:0] up_pred_pc,
  output logic        mispredict,
  output logic [31:0] recover_pc,
  output logic [15:0] mp_count
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT(CTR_W));
  localparam logic [CTR_W-1:0] CTR_NEW = CTR_W'(CTR_ALLOC(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [1:0]         kind_q   [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [15:0]        mp_count_q, mp_count_d;
  logic [CTR_W-1:0]   ctr_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [31:0]      lk_target;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign up_idx = up_pc[IDX_W+1:2];
  assign up_tag = up_pc[TAG_LO+TAG_W-1:TAG_LO];

  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign lk_taken   = lk_hit && (kind_q[lk_idx] != KIND_BR || ctr_q[lk_idx][CTR_W-1]);
  assign lk_next_pc = lk_taken ? lk_target : pc_plus4(lk_pc);

`ifdef BTP_RAS_EN
  logic [31:0] ras_top;
  logic        ras_empty;

  bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (up_valid && up_kind == KIND_CALL),
    .pop_i       (up_valid && up_kind == KIND_RET),
    .push_data_i (pc_plus4(up_pc)),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

  assign lk_target = (kind_q[lk_idx] == KIND_RET && !ras_empty) ? ras_top : target_q[lk_idx];
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  assign lk_target = target_q[lk_idx];
`endif

  assign mispredict = up_valid && ((up_taken != up_pred_taken) ||
                                   (up_taken && up_target != up_pred_pc));
  assign recover_pc = up_taken ? up_target : pc_plus4(up_pc);
  assign mp_count   = mp_count_q;

  always_comb begin
    ctr_d = ctr_q[up_idx];
    if (!up_hit)                                    ctr_d = CTR_NEW;
    else if (up_taken && ctr_q[up_idx] != CTR_MAX)  ctr_d = ctr_q[up_idx] + CTR_W'(1);
    else if (!up_taken && ctr_q[up_idx] != '0)      ctr_d = ctr_q[up_idx] - CTR_W'(1);
  end

  assign mp_count_d = (mispredict && mp_count_q != 16'hFFFF) ? mp_count_q + 16'd1 : mp_count_q;

  // A not-taken miss leaves the slot alone; everything else rewrites it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      mp_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        kind_q[i]   <= KIND_BR;
        ctr_q[i]    <= CTR_RST;
        target_q[i] <= '0;
      end
    end else begin
      mp_count_q <= mp_count_d;
      if (up_valid && (up_hit || up_taken)) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        kind_q[up_idx]  <= up_kind;
        ctr_q[up_idx]   <= ctr_d;
        if (up_taken) target_q[up_idx] <= up_target;
      end
    end
  end

endmodule
